// File: rtl/jtcps1_obj_pkg.sv
// jtcps1_obj_pkg: shared state encoding, attribute field positions and defaults for the object line drawer
package jtcps1_obj_pkg;
    typedef enum logic [3:0] {
        IDLE, RD_ATTR, RD_CODE, RD_Y, RD_X, CHECK, REQ, DRAW, NEXT
    } state_t;
    localparam int M_HI = 15;
    localparam int M_LO = 12;
    localparam int N_HI = 11;
    localparam int N_LO = 8;
    localparam int VFLIP_BIT = 6;
    localparam int HFLIP_BIT = 5;
    localparam logic [7:0] END_MARK = 8'hFF;
    localparam logic [3:0] DEF_TRANSP = 4'hF;
    localparam int DEF_MAXH = 448;
    function automatic logic [7:0] byte_rev(input logic [7:0] b);
        for (int i = 0; i < 8; i++) byte_rev[i] = b[7-i];
    endfunction
endpackage

// File: rtl/jtcps1_obj_pxl_unpack.sv
// jtcps1_obj_pxl_unpack: holds one 8-pixel ROM word and emits one 4bpp colour per shift, honouring hflip
module jtcps1_obj_pxl_unpack
    import jtcps1_obj_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        shift_i,
    input  logic        hflip_i,
    input  logic [31:0] data_i,
    output logic [3:0]  colour_o
);
    logic [31:0] word_q, word_d, load_w;
    // hflip is folded in at load by mirroring each plane byte, so shifting is always towards the MSB
    always_comb begin
        load_w = hflip_i ? {byte_rev(data_i[31:24]), byte_rev(data_i[23:16]),
                            byte_rev(data_i[15:8]), byte_rev(data_i[7:0])} : data_i;
        word_d = load_i ? load_w : shift_i ? (word_q << 1) & 32'hFEFE_FEFE : word_q;
    end
    // plane word register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) word_q <= '0;
        else        word_q <= word_d;
    assign colour_o = {word_q[31], word_q[23], word_q[15], word_q[7]};
endmodule

// File: rtl/jtcps1_obj_line_draw.sv
// jtcps1_obj_line_draw: scans the object table for one line and draws n x m 4bpp sprite rows into the line buffer
module jtcps1_obj_line_draw
    import jtcps1_obj_pkg::*;
#(
    parameter int         AW     = 10,
    parameter int         ROMW   = 20,
    parameter int         HW     = 9,
    parameter int         MAXH   = DEF_MAXH,
    parameter int         PALW   = 5,
    parameter logic [3:0] TRANSP = DEF_TRANSP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      vrender,
    input  logic            start,
    output logic            done,
    output logic [AW-1:0]   table_addr,
    input  logic [15:0]     table_data,
    output logic [HW-1:0]   buf_addr,
    output logic [PALW+3:0] buf_data,
    output logic            buf_wr,
    output logic [ROMW-1:0] rom_addr,
    output logic            rom_half,
    input  logic [31:0]     rom_data,
    output logic            rom_cs,
    input  logic            rom_ok
);
    localparam logic [HW:0] MAXH_W = (HW+1)'(MAXH);

    state_t            state_q, obj_done_st;
    logic [AW-1:0]     table_addr_q;
    logic [15:0]       attr_q, code_q, y_q, x_q, pattr_q, pcode_q, py_q, px_q;
    logic [7:0]        row_q, row_d;
    logic [3:0]        k_q, m, n, vt, ht, vsub, colour;
    logic [2:0]        cnt_q;
    logic              half_q, pend_q, done_q, buf_wr_q, rom_cs_q, rom_half_q;
    logic [HW-1:0]     pos_q, buf_addr_q;
    logic [PALW+3:0]   buf_data_q;
    logic [ROMW-1:0]   rom_addr_q, rom_addr_d;
    logic [15:0]       code_eff;
    logic              vflip, hflip, dup, at_end, clip, rom_take;

    // tile geometry, ROM address and end/clip decisions derived from the latched object
    always_comb begin
        m           = attr_q[M_HI:M_LO];
        n           = attr_q[N_HI:N_LO];
        vflip       = attr_q[VFLIP_BIT];
        hflip       = attr_q[HFLIP_BIT];
        row_d       = vrender - y_q[7:0];
        vt          = vflip ? m - row_q[7:4] : row_q[7:4];
        vsub        = row_q[3:0] ^ {4{vflip}};
        ht          = hflip ? n - k_q : k_q;
        code_eff    = code_q + {12'd0, ht} + {8'd0, vt, 4'd0};
        rom_addr_d  = ROMW'({code_eff, vsub});
        dup         = {attr_q, code_q, y_q, x_q} == {pattr_q, pcode_q, py_q, px_q};
        at_end      = table_addr_q == '1;
        obj_done_st = at_end ? IDLE : RD_ATTR;
        clip        = {1'b0, pos_q} >= MAXH_W && {1'b0, x_q[HW-1:0]} < MAXH_W;
        rom_take    = state_q == REQ && rom_cs_q && rom_ok;
    end

    jtcps1_obj_pxl_unpack u_unpack (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (rom_take),
        .shift_i  (state_q == DRAW),
        .hflip_i  (hflip),
        .data_i   (rom_data),
        .colour_o (colour)
    );

    // scan FSM: table address always leads the word being captured by one cycle to hide RAM latency
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q      <= IDLE;
            table_addr_q <= '1;
            {attr_q, code_q, y_q, x_q}     <= '0;
            {pattr_q, pcode_q, py_q, px_q} <= '0;
            row_q        <= '0;
            k_q          <= '0;
            cnt_q        <= '0;
            half_q       <= 1'b0;
            pend_q       <= 1'b0;
            done_q       <= 1'b0;
            buf_wr_q     <= 1'b0;
            rom_cs_q     <= 1'b0;
            rom_half_q   <= 1'b0;
            pos_q        <= '0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            rom_addr_q   <= '0;
        end else begin
            done_q   <= 1'b0;
            buf_wr_q <= 1'b0;
            if (start && state_q != IDLE) begin
                state_q      <= IDLE;
                table_addr_q <= '1;
                rom_cs_q     <= 1'b0;
                pend_q       <= 1'b1;
            end else case (state_q)
                IDLE: if (start || pend_q) begin
                    pend_q       <= 1'b0;
                    table_addr_q <= table_addr_q - 1'b1;
                    {pattr_q, pcode_q, py_q, px_q} <= '0;
                    state_q      <= RD_ATTR;
                end
                RD_ATTR: if (table_data[15:8] == END_MARK) begin
                    table_addr_q <= '1;
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                end else begin
                    attr_q       <= table_data;
                    table_addr_q <= table_addr_q - 1'b1;
                    state_q      <= RD_CODE;
                end
                RD_CODE: begin
                    code_q       <= table_data;
                    table_addr_q <= table_addr_q - 1'b1;
                    state_q      <= RD_Y;
                end
                RD_Y: begin
                    y_q          <= table_data;
                    table_addr_q <= table_addr_q - 1'b1;
                    state_q      <= RD_X;
                end
                RD_X: begin
                    x_q     <= table_data;
                    state_q <= CHECK;
                end
                CHECK: begin
                    {pattr_q, pcode_q, py_q, px_q} <= {attr_q, code_q, y_q, x_q};
                    row_q   <= row_d;
                    k_q     <= '0;
                    half_q  <= 1'b0;
                    pos_q   <= x_q[HW-1:0];
                    state_q <= row_d[7:4] <= m && !dup ? REQ : obj_done_st;
                    done_q  <= !(row_d[7:4] <= m && !dup) && at_end;
                end
                REQ: if (!rom_cs_q) begin
                    rom_cs_q   <= 1'b1;
                    rom_addr_q <= rom_addr_d;
                    rom_half_q <= half_q ^ hflip;
                end else if (rom_ok) begin
                    rom_cs_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= DRAW;
                end
                DRAW: begin
                    buf_addr_q <= pos_q;
                    buf_data_q <= {attr_q[PALW-1:0], colour};
                    buf_wr_q   <= colour != TRANSP && {1'b0, pos_q} < MAXH_W;
                    pos_q      <= pos_q + 1'b1;
                    cnt_q      <= cnt_q + 1'b1;
                    if (cnt_q == 3'd7) state_q <= NEXT;
                end
                NEXT: if (!half_q) begin
                    half_q  <= 1'b1;
                    state_q <= REQ;
                end else if (k_q == n || clip) begin
                    state_q <= obj_done_st;
                    done_q  <= at_end;
                end else begin
                    k_q     <= k_q + 1'b1;
                    half_q  <= 1'b0;
                    state_q <= REQ;
                end
                default: state_q <= IDLE;
            endcase
        end

    assign done       = done_q;
    assign table_addr = table_addr_q;
    assign buf_addr   = buf_addr_q;
    assign buf_data   = buf_data_q;
    assign buf_wr     = buf_wr_q;
    assign rom_addr   = rom_addr_q;
    assign rom_half   = rom_half_q;
    assign rom_cs     = rom_cs_q;
endmodule

// File: tb/tb_jtcps1_obj_line_draw.sv
// tb_jtcps1_obj_line_draw: directed scenarios for the object line drawer with hand-computed expectations
module tb_jtcps1_obj_line_draw;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  vrender = 8'h00;
    logic        start = 1'b0;
    logic        done;
    logic [9:0]  table_addr;
    logic [15:0] table_data = 16'h0;
    logic [8:0]  buf_addr;
    logic [8:0]  buf_data;
    logic        buf_wr;
    logic [19:0] rom_addr;
    logic        rom_half;
    logic [31:0] rom_data;
    logic        rom_cs;
    logic        rom_ok;

    logic [15:0] tmem [0:1023];
    logic [31:0] rom_w [0:1];
    int          rom_cnt = 0;

    int          errors = 0;
    int          checks = 0;

    int          wr_cnt, nreq, ndone;
    logic [8:0]  line [0:511];
    logic [19:0] req_addr [0:15];
    logic        req_half [0:15];
    logic [8:0]  last_wr;
    logic        cs_prev = 1'b0;
    logic        clr_req = 1'b0;

    jtcps1_obj_line_draw dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vrender    (vrender),
        .start      (start),
        .done       (done),
        .table_addr (table_addr),
        .table_data (table_data),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .buf_wr     (buf_wr),
        .rom_addr   (rom_addr),
        .rom_half   (rom_half),
        .rom_data   (rom_data),
        .rom_cs     (rom_cs),
        .rom_ok     (rom_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) table_data <= tmem[table_addr];
    always @(posedge clk) rom_cnt <= rom_cs ? rom_cnt + 1 : 0;
    assign rom_ok   = rom_cs && rom_cnt == 2;
    assign rom_data = rom_w[rom_half];

    always @(negedge clk) begin
        if (clr_req) begin
            wr_cnt = 0; nreq = 0; ndone = 0; last_wr = 9'h0;
            for (int i = 0; i < 512; i++) line[i] = 9'h0;
        end else begin
            if (buf_wr) begin
                wr_cnt++;
                line[buf_addr] = buf_data;
                last_wr = buf_addr;
            end
            if (rom_cs && !cs_prev && nreq < 16) begin
                req_addr[nreq] = rom_addr;
                req_half[nreq] = rom_half;
                nreq++;
            end
            if (done) ndone++;
        end
        cs_prev = rom_cs;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic init_tab;
        for (int i = 0; i < 1024; i++) tmem[i] = 16'hFF00;
    endtask

    task automatic set_obj(input int slot, input logic [15:0] a, c, y, x);
        tmem[1023-4*slot] = a;
        tmem[1022-4*slot] = c;
        tmem[1021-4*slot] = y;
        tmem[1020-4*slot] = x;
    endtask

    task automatic clear_cap;
        clr_req = 1'b1;
        @(negedge clk);
        @(posedge clk);
        clr_req = 1'b0;
    endtask

    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000 && ndone == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++; if (ndone !== 1) begin errors++; $display("FAIL %s: got %0d done pulses expected 1", name, ndone); end
    endtask

    task automatic run_line(input logic [7:0] vr, input string name);
        vrender = vr;
        clear_cap();
        pulse_start();
        wait_done(name);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (table_addr !== 10'h3FF) begin errors++; $display("FAIL reset_table_addr: got %h expected 3ff", table_addr); end
        checks++; if ({buf_addr, buf_data, buf_wr} !== 19'h0) begin errors++; $display("FAIL reset_buf: got %h/%h/%b expected 0", buf_addr, buf_data, buf_wr); end
        checks++; if ({rom_addr, rom_half, rom_cs, done} !== 23'h0) begin errors++; $display("FAIL reset_rom: got %h/%b/%b/%b expected 0", rom_addr, rom_half, rom_cs, done); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_single;
        int bad = 0;
        init_tab();
        set_obj(0, 16'h0003, 16'h0100, 16'h0020, 16'h0010);
        rom_w[0] = 32'h00FF00FF; rom_w[1] = 32'h00FF00FF;
        run_line(8'h25, "single_done");
        checks++; if (nreq !== 2) begin errors++; $display("FAIL single_nreq: got %0d expected 2", nreq); end
        checks++; if (req_addr[0] !== 20'h01005) begin errors++; $display("FAIL single_addr: got %h expected 01005", req_addr[0]); end
        checks++; if ({req_half[0], req_half[1]} !== 2'b01) begin errors++; $display("FAIL single_halves: got %b%b expected 01", req_half[0], req_half[1]); end
        checks++; if (wr_cnt !== 16) begin errors++; $display("FAIL single_wr_cnt: got %0d expected 16", wr_cnt); end
        for (int a = 16; a < 32; a++) if (line[a] !== 9'h035) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL single_pixels: got %0d wrong, line[010]=%h expected 035", bad, line[16]); end
        checks++; if (table_addr !== 10'h3FF) begin errors++; $display("FAIL single_idle_addr: got %h expected 3ff", table_addr); end
    endtask

    task automatic test_hflip;
        init_tab();
        set_obj(0, 16'h0122, 16'h0200, 16'h0020, 16'h0040);
        rom_w[0] = 32'h80000000; rom_w[1] = 32'h00000001;
        run_line(8'h20, "hflip_done");
        checks++; if (nreq !== 4) begin errors++; $display("FAIL hflip_nreq: got %0d expected 4", nreq); end
        checks++; if ({req_addr[0], req_half[0]} !== {20'h02010, 1'b1}) begin errors++; $display("FAIL hflip_first_req: got %h/%b expected 02010/1", req_addr[0], req_half[0]); end
        checks++; if ({req_addr[2], req_half[1]} !== {20'h02000, 1'b0}) begin errors++; $display("FAIL hflip_order: got %h/%b expected 02000/0", req_addr[2], req_half[1]); end
        checks++; if ({line[64], line[65], line[79], line[78]} !== {9'h021, 9'h020, 9'h028, 9'h020}) begin errors++; $display("FAIL hflip_pixels: got %h %h %h %h expected 021 020 028 020", line[64], line[65], line[79], line[78]); end
        checks++; if ({line[80], wr_cnt} !== {9'h021, 32'd32}) begin errors++; $display("FAIL hflip_tile1: got %h/%0d expected 021/32", line[80], wr_cnt); end
    endtask

    task automatic test_vflip;
        init_tab();
        set_obj(0, 16'h1041, 16'h0300, 16'h0040, 16'h0080);
        rom_w[0] = 32'h00FF00FF; rom_w[1] = 32'h00FF00FF;
        run_line(8'h43, "vflip_done");
        checks++; if ({req_addr[0], req_half[0]} !== {20'h0310C, 1'b0}) begin errors++; $display("FAIL vflip_addr: got %h/%b expected 0310c/0", req_addr[0], req_half[0]); end
        checks++; if ({line[128], wr_cnt} !== {9'h015, 32'd16}) begin errors++; $display("FAIL vflip_pixels: got %h/%0d expected 015/16", line[128], wr_cnt); end
        run_line(8'h5F, "vflip_last_row_done");
        checks++; if (req_addr[0] !== 20'h03000) begin errors++; $display("FAIL vflip_last_row: got %h expected 03000", req_addr[0]); end
        run_line(8'h60, "vflip_below_done");
        checks++; if ({nreq, wr_cnt} !== 64'd0) begin errors++; $display("FAIL vflip_below_skip: got %0d reqs %0d writes expected 0 0", nreq, wr_cnt); end
    endtask

    task automatic test_transparency;
        init_tab();
        set_obj(0, 16'h0004, 16'h0400, 16'h0010, 16'h0100);
        rom_w[0] = 32'hFFFFFFFF; rom_w[1] = 32'hFFFFFFFF;
        run_line(8'h10, "transp_done");
        checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL transp_writes: got %0d expected 0", wr_cnt); end
        checks++; if ({nreq, 23'd0, buf_addr} !== {32'd2, 23'd0, 9'h10F}) begin errors++; $display("FAIL transp_advance: got %0d reqs addr %h expected 2 reqs addr 10f", nreq, buf_addr); end
    endtask

    task automatic test_clip_end;
        init_tab();
        set_obj(0, 16'h0307, 16'h0500, 16'h0000, 16'h01BC);
        rom_w[0] = 32'h00FF00FF; rom_w[1] = 32'h00FF00FF;
        run_line(8'h00, "clip_done");
        checks++; if ({wr_cnt, 23'd0, last_wr} !== {32'd4, 23'd0, 9'h1BF}) begin errors++; $display("FAIL clip_writes: got %0d last %h expected 4 last 1bf", wr_cnt, last_wr); end
        checks++; if ({nreq, line[447]} !== {32'd2, 9'h075}) begin errors++; $display("FAIL clip_tiles: got %0d reqs line[1bf]=%h expected 2 075", nreq, line[447]); end
        checks++; if ({rom_cs, table_addr} !== {1'b0, 10'h3FF}) begin errors++; $display("FAIL end_idle: got cs %b addr %h expected 0 3ff", rom_cs, table_addr); end
    endtask

    task automatic test_duplicate;
        init_tab();
        set_obj(0, 16'h0003, 16'h0100, 16'h0020, 16'h0010);
        set_obj(1, 16'h0003, 16'h0100, 16'h0020, 16'h0010);
        rom_w[0] = 32'h00FF00FF; rom_w[1] = 32'h00FF00FF;
        run_line(8'h25, "dup_done");
        checks++; if ({nreq, wr_cnt} !== {32'd2, 32'd16}) begin errors++; $display("FAIL dup_skip: got %0d reqs %0d writes expected 2 16", nreq, wr_cnt); end
    endtask

    task automatic test_restart;
        init_tab();
        set_obj(0, 16'h0003, 16'h0100, 16'h0020, 16'h0010);
        rom_w[0] = 32'h00FF00FF; rom_w[1] = 32'h00FF00FF;
        vrender = 8'h25;
        clear_cap();
        pulse_start();
        for (int i = 0; i < 100 && !rom_cs; i++) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done("restart_done");
        checks++; if ({nreq, wr_cnt} !== {32'd3, 32'd16}) begin errors++; $display("FAIL restart_rescan: got %0d reqs %0d writes expected 3 16", nreq, wr_cnt); end
        checks++; if (req_addr[1] !== 20'h01005) begin errors++; $display("FAIL restart_addr: got %h expected 01005", req_addr[1]); end
    endtask

    task automatic test_reset_mid;
        vrender = 8'h25;
        clear_cap();
        pulse_start();
        for (int i = 0; i < 100 && !rom_cs; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({rom_cs, rom_addr, rom_half, table_addr} !== {1'b0, 20'h0, 1'b0, 10'h3FF}) begin errors++; $display("FAIL reset_mid: got cs %b addr %h half %b taddr %h expected 0 00000 0 3ff", rom_cs, rom_addr, rom_half, table_addr); end
        checks++; if ({buf_addr, buf_data, buf_wr, done} !== 20'h0) begin errors++; $display("FAIL reset_mid_buf: got %h/%h/%b/%b expected 0", buf_addr, buf_data, buf_wr, done); end
        @(negedge clk) rst_n = 1'b1;
        run_line(8'h25, "reset_mid_rescan_done");
        checks++; if ({nreq, wr_cnt} !== {32'd2, 32'd16}) begin errors++; $display("FAIL reset_mid_rescan: got %0d reqs %0d writes expected 2 16", nreq, wr_cnt); end
    endtask

    initial begin
        init_tab();
        rom_w[0] = 32'h0; rom_w[1] = 32'h0;
        test_reset();
        test_single();
        test_hflip();
        test_vflip();
        test_transparency();
        test_clip_end();
        test_duplicate();
        test_restart();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
